// File: rtl/riscv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared types and constants for the multi-cycle RV64 control unit:
//   - sequencer state encoding
//   - supported opcode values (instr[6:0])
//   - instruction class produced by the opcode decoder
//   - immediate-format and ALU-operation encodings
//   - the packed control-output bundle driven by the sequencer
// -----------------------------------------------------------------------------
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_R     = 3'd0,
        CLS_I_ALU = 3'd1,
        CLS_LD    = 3'd2,
        CLS_SD    = 3'd3,
        CLS_BEQ   = 3'd4,
        CLS_ILL   = 3'd5
    } iclass_t;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU = 7'b0010011;
    localparam logic [6:0] OPC_LD    = 7'b0000011;
    localparam logic [6:0] OPC_SD    = 7'b0100011;
    localparam logic [6:0] OPC_BEQ   = 7'b1100011;

    // Immediate formats; these coincide with opcode[6:5] of the supported set.
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic       imem_req;
        logic       ir_write;
        logic       dmem_read;
        logic       dmem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [1:0] alu_op;
        logic [1:0] imm_sel;
        logic       pc_write;
        logic       pc_src;
        logic       illegal_instr;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = ctrl_t'(14'd0);

    // Classes whose ALU operand B is the immediate.
    function automatic logic cls_uses_imm(input iclass_t cls);
        logic res;
        case (cls)
            CLS_I_ALU, CLS_LD, CLS_SD: res = 1'b1;
            default:                   res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit_if
// Bundles the control unit's datapath/memory-facing signals.
//   master modport (control unit):
//     in : opcode[OPC_W], alu_zero, imem_ready, dmem_ready
//     out: imem_req, ir_write, dmem_read, dmem_write, reg_write, mem_to_reg,
//          alu_src, alu_op[2], imm_sel[2], pc_write, pc_src, illegal_instr,
//          instret[PERF_W] (only when MCU_PERF_CNT_EN is defined)
//   slave modport: the mirror image, for the datapath/memory side.
// Optional feature macro: MCU_PERF_CNT_EN (adds the instret signal).
// -----------------------------------------------------------------------------
interface multicycle_control_unit_if #(
    parameter int OPC_W  = 7,
    parameter int PERF_W = 64
);
    logic [OPC_W-1:0] opcode;
    logic             alu_zero;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             ir_write;
    logic             dmem_read;
    logic             dmem_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic [1:0]       imm_sel;
    logic             pc_write;
    logic             pc_src;
    logic             illegal_instr;
`ifdef MCU_PERF_CNT_EN
    logic [PERF_W-1:0] instret;
`else
    logic              unused_perf_w;
    assign unused_perf_w = (PERF_W > 0);
`endif

    modport master (
`ifdef MCU_PERF_CNT_EN
        output instret,
`endif
        input  opcode, alu_zero, imem_ready, dmem_ready,
        output imem_req, ir_write, dmem_read, dmem_write, reg_write,
               mem_to_reg, alu_src, alu_op, imm_sel, pc_write, pc_src,
               illegal_instr
    );

    modport slave (
`ifdef MCU_PERF_CNT_EN
        input  instret,
`endif
        output opcode, alu_zero, imem_ready, dmem_ready,
        input  imem_req, ir_write, dmem_read, dmem_write, reg_write,
               mem_to_reg, alu_src, alu_op, imm_sel, pc_write, pc_src,
               illegal_instr
    );

endinterface

// File: rtl/mcu_opcode_decoder.sv
// -----------------------------------------------------------------------------
// mcu_opcode_decoder
// Combinational classification of instr[6:0] into an instruction class.
//   i_opcode  in  OPC_W  opcode field from the instruction register
//   o_class   out        instruction class (CLS_ILL when unsupported)
//   o_illegal out  1     opcode is outside the supported set
// -----------------------------------------------------------------------------
module mcu_opcode_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter int OPC_W = 7
) (
    input  logic [OPC_W-1:0] i_opcode,
    output iclass_t          o_class,
    output logic             o_illegal
);

    // opcode lookup; anything not listed is illegal
    always_comb begin
        o_class   = CLS_ILL;
        o_illegal = 1'b1;
        case (i_opcode)
            OPC_R:     begin o_class = CLS_R;     o_illegal = 1'b0; end
            OPC_I_ALU: begin o_class = CLS_I_ALU; o_illegal = 1'b0; end
            OPC_LD:    begin o_class = CLS_LD;    o_illegal = 1'b0; end
            OPC_SD:    begin o_class = CLS_SD;    o_illegal = 1'b0; end
            OPC_BEQ:   begin o_class = CLS_BEQ;   o_illegal = 1'b0; end
            default:   begin o_class = CLS_ILL;   o_illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
// Multi-cycle sequencer (FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP) for the
// RV64 datapath. Supports R-type, I-ALU, LD, SD and BEQ; other opcodes trap.
//   clk    in  1  rising-edge clock
//   reset  in  1  synchronous, active-low reset
//   bus    master modport of multicycle_control_unit_if (opcode, alu_zero,
//          imem_ready, dmem_ready in; datapath enables/selects out)
// Optional feature macro: MCU_PERF_CNT_EN adds a PERF_W-bit retired-instruction
// counter on bus.instret; without it no counter flops exist.
// While reset is low every control output is held at 0, so a handshake that
// was in flight is dropped immediately rather than one cycle later.
// -----------------------------------------------------------------------------
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int OPC_W  = 7,
    parameter int PERF_W = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_control_unit_if.master bus
);

    state_t      r_state;
    state_t      w_next;
    iclass_t     r_class;
    logic [1:0]  r_imm_sel;
    iclass_t     w_dec_class;
    logic        w_dec_illegal;
    ctrl_t       w_ctrl_fsm;
    ctrl_t       w_ctrl;

    mcu_opcode_decoder #(.OPC_W(OPC_W)) u_dec (
        .i_opcode  (bus.opcode),
        .o_class   (w_dec_class),
        .o_illegal (w_dec_illegal)
    );

    // state register plus per-instruction context captured in DECODE
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_FETCH;
            r_class   <= CLS_ILL;
            r_imm_sel <= IMM_I;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_class   <= w_dec_class;
                r_imm_sel <= bus.opcode[6:5];
            end else begin
                r_class   <= r_class;
                r_imm_sel <= r_imm_sel;
            end
        end
    end

    // next-state and control outputs
    always_comb begin
        w_next     = r_state;
        w_ctrl_fsm = CTRL_NONE;
        case (r_state)
            ST_FETCH: begin
                w_ctrl_fsm.imem_req = 1'b1;
                w_ctrl_fsm.ir_write = bus.imem_ready;
                if (bus.imem_ready) begin
                    w_next = ST_DECODE;
                end else begin
                    w_next = ST_FETCH;
                end
            end
            ST_DECODE: begin
                // Selects come straight from the decoder this cycle so they are
                // already stable before EXECUTE uses them.
                w_ctrl_fsm.imm_sel    = bus.opcode[6:5];
                w_ctrl_fsm.alu_src    = cls_uses_imm(w_dec_class);
                w_ctrl_fsm.mem_to_reg = (w_dec_class == CLS_LD);
                if (w_dec_illegal) begin
                    w_next = ST_TRAP;
                end else begin
                    w_next = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                w_ctrl_fsm.imm_sel    = r_imm_sel;
                w_ctrl_fsm.alu_src    = cls_uses_imm(r_class);
                w_ctrl_fsm.mem_to_reg = (r_class == CLS_LD);
                case (r_class)
                    CLS_R, CLS_I_ALU: begin
                        w_ctrl_fsm.alu_op = ALU_FUNCT;
                        w_next            = ST_WRITEBACK;
                    end
                    CLS_LD, CLS_SD: begin
                        w_ctrl_fsm.alu_op = ALU_ADD;
                        w_next            = ST_MEM;
                    end
                    CLS_BEQ: begin
                        w_ctrl_fsm.alu_op   = ALU_SUB;
                        w_ctrl_fsm.pc_write = 1'b1;
                        w_ctrl_fsm.pc_src   = bus.alu_zero;
                        w_next              = ST_FETCH;
                    end
                    default: begin
                        w_next = ST_TRAP;
                    end
                endcase
            end
            ST_MEM: begin
                w_ctrl_fsm.imm_sel    = r_imm_sel;
                w_ctrl_fsm.alu_src    = cls_uses_imm(r_class);
                w_ctrl_fsm.mem_to_reg = (r_class == CLS_LD);
                w_ctrl_fsm.dmem_read  = (r_class == CLS_LD);
                w_ctrl_fsm.dmem_write = (r_class == CLS_SD);
                if (bus.dmem_ready) begin
                    if (r_class == CLS_LD) begin
                        w_next = ST_WRITEBACK;
                    end else begin
                        // store retires here: advance PC to PC+4
                        w_ctrl_fsm.pc_write = 1'b1;
                        w_next              = ST_FETCH;
                    end
                end else begin
                    w_next = ST_MEM;
                end
            end
            ST_WRITEBACK: begin
                w_ctrl_fsm.imm_sel    = r_imm_sel;
                w_ctrl_fsm.alu_src    = cls_uses_imm(r_class);
                w_ctrl_fsm.mem_to_reg = (r_class == CLS_LD);
                w_ctrl_fsm.reg_write  = 1'b1;
                w_ctrl_fsm.pc_write   = 1'b1;
                w_next                = ST_FETCH;
            end
            ST_TRAP: begin
                w_ctrl_fsm.illegal_instr = 1'b1;
                w_next                   = ST_TRAP;
            end
            default: begin
                w_next = ST_FETCH;
            end
        endcase
    end

    assign w_ctrl = reset ? w_ctrl_fsm : CTRL_NONE;

    assign bus.imem_req      = w_ctrl.imem_req;
    assign bus.ir_write      = w_ctrl.ir_write;
    assign bus.dmem_read     = w_ctrl.dmem_read;
    assign bus.dmem_write    = w_ctrl.dmem_write;
    assign bus.reg_write     = w_ctrl.reg_write;
    assign bus.mem_to_reg    = w_ctrl.mem_to_reg;
    assign bus.alu_src       = w_ctrl.alu_src;
    assign bus.alu_op        = w_ctrl.alu_op;
    assign bus.imm_sel       = w_ctrl.imm_sel;
    assign bus.pc_write      = w_ctrl.pc_write;
    assign bus.pc_src        = w_ctrl.pc_src;
    assign bus.illegal_instr = w_ctrl.illegal_instr;

`ifdef MCU_PERF_CNT_EN
    logic [PERF_W-1:0] r_instret;
    logic              w_retire;

    // An instruction retires in WRITEBACK, in BEQ's EXECUTE, or when a store completes.
    assign w_retire = (r_state == ST_WRITEBACK)
                    | ((r_state == ST_EXECUTE) & (r_class == CLS_BEQ))
                    | ((r_state == ST_MEM) & (r_class == CLS_SD) & bus.dmem_ready);

    // retired-instruction counter, wraps naturally at 2^PERF_W
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_instret <= {PERF_W{1'b0}};
        end else if (w_retire) begin
            r_instret <= r_instret + {{(PERF_W-1){1'b0}}, 1'b1};
        end else begin
            r_instret <= r_instret;
        end
    end

    assign bus.instret = r_instret;
`else
    logic w_unused_perf_w;
    assign w_unused_perf_w = (PERF_W > 0);
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
// Directed, self-checking bench for multicycle_control_unit. Each cycle drives
// the ready/zero inputs after the rising edge and compares the full control
// vector against a hand-computed value. Vector bit order (MSB..LSB):
//   imem_req ir_write dmem_read dmem_write reg_write mem_to_reg alu_src
//   alu_op[1:0] imm_sel[1:0] pc_write pc_src illegal_instr
// Build with MCU_PERF_CNT_EN defined to also check the instret counter.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;
    import riscv_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    multicycle_control_unit_if bus_if ();

    multicycle_control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    localparam logic [13:0] E_NONE   = 14'b0_0_0_0_0_0_0_00_00_0_0_0;
    localparam logic [13:0] E_FETCH  = 14'b1_0_0_0_0_0_0_00_00_0_0_0;
    localparam logic [13:0] E_IRW    = 14'b1_1_0_0_0_0_0_00_00_0_0_0;
    localparam logic [13:0] E_TRAP   = 14'b0_0_0_0_0_0_0_00_00_0_0_1;

    function automatic logic [13:0] ov();
        return {bus_if.imem_req, bus_if.ir_write, bus_if.dmem_read,
                bus_if.dmem_write, bus_if.reg_write, bus_if.mem_to_reg,
                bus_if.alu_src, bus_if.alu_op, bus_if.imm_sel,
                bus_if.pc_write, bus_if.pc_src, bus_if.illegal_instr};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // one clock cycle: drive inputs just after the edge, then compare outputs
    task automatic cyc(input string tag, input logic imr, input logic dmr,
                       input logic az, input logic [13:0] exp);
        @(posedge clk);
        #1;
        bus_if.imem_ready = imr;
        bus_if.dmem_ready = dmr;
        bus_if.alu_zero   = az;
        #1;
        check_eq(tag, 64'(ov()), 64'(exp));
    endtask

    initial begin
        bus_if.opcode     = 7'd0;
        bus_if.imem_ready = 1'b0;
        bus_if.dmem_ready = 1'b0;
        bus_if.alu_zero   = 1'b0;

        // reset: outputs forced low even with inputs asserted
        cyc("rst_a", 1'b0, 1'b0, 1'b0, E_NONE);
        cyc("rst_b", 1'b1, 1'b1, 1'b1, E_NONE);
        reset = 1'b1;
        bus_if.imem_ready = 1'b0;
        #1;
        check_eq("fetch_wait", 64'(ov()), 64'(E_FETCH));
`ifdef MCU_PERF_CNT_EN
        check_eq("instret_rst", bus_if.instret, 64'd0);
`endif

        // R-type, imem_ready always 1
        bus_if.opcode = OPC_R;
        cyc("r_c0_fetch", 1'b1, 1'b0, 1'b0, E_IRW);
        cyc("r_c1_dec",   1'b1, 1'b0, 1'b0, 14'b0_0_0_0_0_0_0_00_01_0_0_0);
        cyc("r_c2_exe",   1'b1, 1'b0, 1'b0, 14'b0_0_0_0_0_0_0_10_01_0_0_0);
        cyc("r_c3_wb",    1'b1, 1'b0, 1'b0, 14'b0_0_0_0_1_0_0_00_01_1_0_0);
        cyc("r_c4_fetch", 1'b1, 1'b0, 1'b0, E_IRW);

        // LD, dmem_ready high early (ignored) then delayed 2 cycles in MEM
        bus_if.opcode = OPC_LD;
        cyc("ld_c1_dec",  1'b1, 1'b1, 1'b0, 14'b0_0_0_0_0_1_1_00_00_0_0_0);
        cyc("ld_c2_exe",  1'b1, 1'b1, 1'b0, 14'b0_0_0_0_0_1_1_00_00_0_0_0);
        cyc("ld_c3_mem",  1'b0, 1'b0, 1'b0, 14'b0_0_1_0_0_1_1_00_00_0_0_0);
        cyc("ld_c4_mem",  1'b0, 1'b0, 1'b0, 14'b0_0_1_0_0_1_1_00_00_0_0_0);
        cyc("ld_c5_mem",  1'b0, 1'b1, 1'b0, 14'b0_0_1_0_0_1_1_00_00_0_0_0);
        cyc("ld_c6_wb",   1'b0, 1'b0, 1'b0, 14'b0_0_0_0_1_1_1_00_00_1_0_0);
        cyc("ld_c7_wait", 1'b0, 1'b0, 1'b0, E_FETCH);

        // SD, zero-wait memory
        bus_if.opcode = OPC_SD;
        cyc("sd_c0_fetch", 1'b1, 1'b0, 1'b0, E_IRW);
        cyc("sd_c1_dec",   1'b0, 1'b0, 1'b0, 14'b0_0_0_0_0_0_1_00_01_0_0_0);
        cyc("sd_c2_exe",   1'b0, 1'b0, 1'b0, 14'b0_0_0_0_0_0_1_00_01_0_0_0);
        cyc("sd_c3_mem",   1'b0, 1'b1, 1'b0, 14'b0_0_0_1_0_0_1_00_01_1_0_0);
        cyc("sd_c4_fetch", 1'b1, 1'b0, 1'b0, E_IRW);

        // BEQ taken
        bus_if.opcode = OPC_BEQ;
        cyc("beq1_c1_dec",   1'b0, 1'b0, 1'b1, 14'b0_0_0_0_0_0_0_00_11_0_0_0);
        cyc("beq1_c2_exe",   1'b0, 1'b0, 1'b1, 14'b0_0_0_0_0_0_0_01_11_1_1_0);
        cyc("beq1_c3_fetch", 1'b1, 1'b0, 1'b0, E_IRW);
`ifdef MCU_PERF_CNT_EN
        check_eq("instret_4", bus_if.instret, 64'd4);
`endif

        // BEQ not taken
        cyc("beq0_c1_dec",   1'b0, 1'b0, 1'b0, 14'b0_0_0_0_0_0_0_00_11_0_0_0);
        cyc("beq0_c2_exe",   1'b0, 1'b0, 1'b0, 14'b0_0_0_0_0_0_0_01_11_1_0_0);
        bus_if.opcode = OPC_I_ALU;
        cyc("beq0_c3_fetch", 1'b1, 1'b0, 1'b0, E_IRW);

        // I-ALU
        cyc("ialu_c1_dec",   1'b0, 1'b0, 1'b0, 14'b0_0_0_0_0_0_1_00_00_0_0_0);
        cyc("ialu_c2_exe",   1'b0, 1'b0, 1'b0, 14'b0_0_0_0_0_0_1_10_00_0_0_0);
        cyc("ialu_c3_wb",    1'b0, 1'b0, 1'b0, 14'b0_0_0_0_1_0_1_00_00_1_0_0);
        bus_if.opcode = OPC_LD;
        cyc("ialu_c4_fetch", 1'b1, 1'b0, 1'b0, E_IRW);
`ifdef MCU_PERF_CNT_EN
        check_eq("instret_6", bus_if.instret, 64'd6);
`endif

        // reset while LD waits in MEM
        cyc("ldr_c1_dec", 1'b0, 1'b0, 1'b0, 14'b0_0_0_0_0_1_1_00_00_0_0_0);
        cyc("ldr_c2_exe", 1'b0, 1'b0, 1'b0, 14'b0_0_0_0_0_1_1_00_00_0_0_0);
        cyc("ldr_c3_mem", 1'b0, 1'b0, 1'b0, 14'b0_0_1_0_0_1_1_00_00_0_0_0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_eq("ldr_rst_gate", 64'(ov()), 64'(E_NONE));
        @(posedge clk);
        #1;
        check_eq("ldr_rst_edge", 64'(ov()), 64'(E_NONE));
        reset = 1'b1;
        #1;
        check_eq("ldr_in_fetch", 64'(ov()), 64'(E_FETCH));
`ifdef MCU_PERF_CNT_EN
        check_eq("instret_clr", bus_if.instret, 64'd0);
`endif

        // illegal opcode traps and stays trapped
        bus_if.opcode = 7'b1111111;
        cyc("trap_c0_fetch", 1'b1, 1'b0, 1'b0, E_IRW);
        cyc("trap_c1_dec",   1'b1, 1'b1, 1'b1, 14'b0_0_0_0_0_0_0_00_11_0_0_0);
        for (int i = 0; i < 12; i++) begin
            cyc("trap_hold", 1'(i % 2), 1'((i + 1) % 2), 1'b1, E_TRAP);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus_if.imem_ready = 1'b0;
        #1;
        check_eq("trap_rst_gate", 64'(ov()), 64'(E_NONE));
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_eq("trap_cleared", 64'(ov()), 64'(E_FETCH));

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
